// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and a reference adder function for full_adder_reg.
//   MAX_WIDTH : widest legal operand width
//   SUM_RST   : reset value of the registered sum (sliced to WIDTH by users)
//   COUT_RST  : reset value of the registered carry out
//   ref_add   : MAX_WIDTH+1 bit a+b+cin. Callers zero-extend narrower operands
//               and take bits [WIDTH:0]; the carry then lands in bit WIDTH.
// -----------------------------------------------------------------------------
package full_adder_pkg;

   localparam int MAX_WIDTH = 64;

   localparam logic [MAX_WIDTH-1:0] SUM_RST  = '0;
   localparam logic                 COUT_RST = 1'b0;

   function automatic logic [MAX_WIDTH:0] ref_add(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input logic                 cin
   );
      return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One-bit combinational full-adder cell, the ripple element of full_adder_reg.
// Ports:
//   a, b  : operand bits
//   cin   : carry into this bit
//   s     : sum bit      = a ^ b ^ cin
//   cout  : carry out    = a&b | cin&(a^b)
// -----------------------------------------------------------------------------
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   // Propagate term is shared by the sum and the carry.
   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_reg.sv
// -----------------------------------------------------------------------------
// full_adder_reg
// Registered WIDTH-bit ripple-carry adder: {carry_out, sum} <= a + b + carry_in.
// One-cycle latency, one result per cycle, no handshake.
// Parameters:
//   WIDTH     : operand/sum width, 1..64
// Ports:
//   clk       : rising-edge clock
//   rstn      : asynchronous active-low reset
//   a, b      : operands, sampled every rising edge
//   carry_in  : carry into bit 0
//   sum       : registered sum bits
//   carry_out : registered carry out of bit WIDTH-1
//   out_valid : set by the first edge after reset release, held until reset
// Build option:
//   FULL_ADDER_ASSERT_EN : when defined, elaborates embedded assertions and
//                          cover properties. Functional logic is unchanged.
// -----------------------------------------------------------------------------
module full_adder_reg
   import full_adder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             out_valid
);

   logic [WIDTH-1:0] sum_c;
   logic             cout_c;

   // Carry chain. Each stage keeps its own carry nets and reaches back into
   // the previous stage, so no single vector feeds back into itself.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic ci;
      logic co;

      if (gi == 0) begin : g_first
         assign ci = carry_in;
      end else begin : g_rest
         assign ci = g_bit[gi-1].co;
      end

      full_adder_bit u_bit (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (ci),
         .s    (sum_c[gi]),
         .cout (co)
      );
   end

   assign cout_c = g_bit[WIDTH-1].co;

   logic [WIDTH-1:0] sum_d,       sum_q;
   logic             carry_out_d, carry_out_q;
   logic             out_valid_d, out_valid_q;

   always_comb begin
      sum_d       = sum_c;
      carry_out_d = cout_c;
      // Any edge out of reset produces a result from post-release inputs.
      out_valid_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum_q       <= SUM_RST[WIDTH-1:0];
         carry_out_q <= COUT_RST;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign out_valid = out_valid_q;

`ifdef FULL_ADDER_ASSERT_EN
   logic [MAX_WIDTH:0] ref_full;
   logic [WIDTH:0]     ref_res;

   assign ref_full = ref_add(MAX_WIDTH'(a), MAX_WIDTH'(b), carry_in);
   assign ref_res  = ref_full[WIDTH:0];

   // The previous cycle must also be out of reset, otherwise the flops
   // were held cleared rather than loaded.
   a_result : assert property (@(posedge clk) disable iff (!rstn)
      $past(rstn) |-> ({carry_out, sum} == $past(ref_res)));

   a_valid_sticky : assert property (@(posedge clk) disable iff (!rstn)
      out_valid |=> out_valid);

   // Reset clears asynchronously, so this is checked combinationally.
   always_comb begin
      if (!rstn) begin
         a_reset_vals : assert (sum == '0 && carry_out == 1'b0 && out_valid == 1'b0);
      end
   end

   c_carry    : cover property (@(posedge clk) disable iff (!rstn) carry_out);
   c_zero_sum : cover property (@(posedge clk) disable iff (!rstn)
      out_valid && (sum == '0));
   c_all_ones : cover property (@(posedge clk) disable iff (!rstn)
      (&a) && (&b) && carry_in);
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// -----------------------------------------------------------------------------
// tb_full_adder_reg
// Drives an 8-bit and a 1-bit full_adder_reg from one clock and reset.
// Inputs change 1 time unit after each rising edge; outputs are compared
// against a plain-arithmetic model on every falling edge, plus literal checks.
// -----------------------------------------------------------------------------
module tb_full_adder_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn = 1'b1;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       cin8 = 1'b0, cout8, v8;
   logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, sum1, cout1, v1;

   int n_checks = 0;
   int n_fail   = 0;

   full_adder_reg #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rstn      (rstn),
      .a         (a8),
      .b         (b8),
      .carry_in  (cin8),
      .sum       (sum8),
      .carry_out (cout8),
      .out_valid (v8)
   );

   full_adder_reg #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rstn      (rstn),
      .a         (a1),
      .b         (b1),
      .carry_in  (cin1),
      .sum       (sum1),
      .carry_out (cout1),
      .out_valid (v1)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: integer sum of what was present at the last edge out of reset.
   int  exp8_val = 0;
   int  exp1_val = 0;
   bit  exp_valid = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp8_val  = 0;
         exp1_val  = 0;
         exp_valid = 1'b0;
      end else begin
         exp8_val  = int'(a8) + int'(b8) + int'(cin8);
         exp1_val  = int'(a1) + int'(b1) + int'(cin1);
         exp_valid = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("sum8",   64'(sum8),  64'(exp8_val % 256));
      chk("cout8",  64'(cout8), 64'(exp8_val / 256));
      chk("valid8", 64'(v8),    64'(exp_valid));
      chk("sum1",   64'(sum1),  64'(exp1_val % 2));
      chk("cout1",  64'(cout1), 64'(exp1_val / 2));
      chk("valid1", 64'(v1),    64'(exp_valid));
      $display("cyc a8=%02h b8=%02h c=%0d -> sum8=%02h co=%0d v=%0d | a1=%0d b1=%0d c=%0d -> s=%0d co=%0d",
               a8, b8, cin8, sum8, cout8, v8, a1, b1, cin1, sum1, cout1);
   end

   // Apply one vector to both DUTs, then check literal results one edge later.
   task automatic apply_lit(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v,
                            input logic [7:0] s_exp, input logic co_exp,
                            input logic a1_v, input logic b1_v, input logic c1_v,
                            input logic s1_exp, input logic co1_exp);
      @(posedge clk);
      #1;
      a8 = a_v;  b8 = b_v;  cin8 = c_v;
      a1 = a1_v; b1 = b1_v; cin1 = c1_v;
      @(posedge clk);
      #2;
      chk("lit_sum8",  64'(sum8),  64'(s_exp));
      chk("lit_cout8", 64'(cout8), 64'(co_exp));
      chk("lit_v8",    64'(v8),    64'd1);
      chk("lit_sum1",  64'(sum1),  64'(s1_exp));
      chk("lit_cout1", 64'(cout1), 64'(co1_exp));
   endtask

   initial begin
      logic [2:0] combo;

      // Reset held with toggling inputs.
      #2 rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
         #1;
         chk("rst_sum8", 64'(sum8), 64'd0);
         chk("rst_v8",   64'(v8),   64'd0);
         chk("rst_cout1", 64'(cout1), 64'd0);
      end
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("first_valid8", 64'(v8), 64'd1);
      chk("first_valid1", 64'(v1), 64'd1);

      // Directed literal vectors.
      apply_lit(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      apply_lit(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      apply_lit(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      apply_lit(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // WIDTH=1 exhaustive on consecutive cycles; model checks each result.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         combo = 3'(i);
         a1 = combo[2]; b1 = combo[1]; cin1 = combo[0];
         a8 = {5'd0, combo}; b8 = 8'(i * 37); cin8 = combo[0];
      end

      // Mid-stream reset with 0xA5 in the output register.
      apply_lit(8'h50, 8'h55, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 rstn = 1'b0;
      #1;
      chk("mid_sum8",   64'(sum8), 64'd0);
      chk("mid_v8",     64'(v8),   64'd0);
      chk("mid_sum1",   64'(sum1), 64'd0);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_sum8",  64'(sum8), 64'h47);
      chk("post_v8",    64'(v8),   64'd1);

      // Random stimulus with occasional mid-cycle reset pulses.
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
         end
         a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #1 rstn = 1'b0;
            #1;
            chk("rnd_rst_v8",   64'(v8),   64'd0);
            chk("rnd_rst_sum8", 64'(sum8), 64'd0);
            #1 rstn = 1'b1;
         end
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
